vga_sync_gen: RTL and testbench

Timing generator directly upstream of the pixel colour stage. It produces the CounterX/CounterY raster position consumed by the colour logic. It also produces the hsync/vsync pins, a visible-area flag, and a per-frame tick that the game-state logic uses to update ball and paddle positions once per frame. Default timing is 640x480@60 Hz from a 25 MHz pixel rate.

---
 rtl/vga_sync_gen.sv | 76 +++++++
 tb/tb_vga_sync_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters plus registered sync, visible-area flag and line/frame pulses, all aligned to the counters.
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       hsync,
  output logic       vsync,
  output logic       in_display,
  output logic       frame_start,
  output logic       line_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] r_x, r_y, w_nx, w_ny;
  logic       r_hs, r_vs, r_disp, r_fs, r_ls;
  logic       w_x_wrap, w_hact, w_vact, w_disp;
  // Decode from the next counter values so the registered flags line up with the registered counters.
  always_comb begin
    w_x_wrap = r_x == H_LAST;
    w_nx     = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_ny     = w_x_wrap ? ((r_y == V_LAST) ? 10'd0 : r_y + 10'd1) : r_y;
    w_hact   = {1'b0, w_nx} >= HS_BEG && {1'b0, w_nx} < HS_END;
    w_vact   = {1'b0, w_ny} >= VS_BEG && {1'b0, w_ny} < VS_END;
    w_disp   = {1'b0, w_nx} < H_VIS && {1'b0, w_ny} < V_VIS;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= H_LAST;
      r_y    <= V_LAST;
      r_hs   <= ~SYNC_ACTIVE;
      r_vs   <= ~SYNC_ACTIVE;
      r_disp <= 1'b0;
      r_fs   <= 1'b0;
      r_ls   <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      r_ls <= 1'b0;
      if (pix_en) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_hs   <= w_hact ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_vs   <= w_vact ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        r_disp <= w_disp;
        r_ls   <= w_nx == 10'd0;
        r_fs   <= w_nx == 10'd0 && w_ny == 10'd0;
      end
    end
  end
  assign CounterX    = r_x;
  assign CounterY    = r_y;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign in_display  = r_disp;
  assign frame_start = r_fs;
  assign line_start  = r_ls;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks a default 640x480 instance and a tiny-raster instance against an arithmetic position model.
module tb_vga_sync_gen;
  logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
  logic [9:0] d_x, d_y, s_x, s_y;
  logic d_hs, d_vs, d_disp, d_fs, d_ls;
  logic s_hs, s_vs, s_disp, s_fs, s_ls;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  vga_sync_gen u_d (
    .clk(clk), .reset(reset), .pix_en(pix_en), .CounterX(d_x), .CounterY(d_y),
    .hsync(d_hs), .vsync(d_vs), .in_display(d_disp), .frame_start(d_fs), .line_start(d_ls)
  );
  // Tiny raster: 16 columns x 11 lines, 176 pixels per frame.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b0)
  ) u_s (
    .clk(clk), .reset(reset), .pix_en(pix_en), .CounterX(s_x), .CounterY(s_y),
    .hsync(s_hs), .vsync(s_vs), .in_display(s_disp), .frame_start(s_fs), .line_start(s_ls)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct {int x; int y; bit hs; bit vs; bit disp; bit fs; bit ls;} exp_t;
  // k counts enabled edges since reset release; the raster position is simply k-1 modulo the frame size.
  function automatic exp_t model(input longint k, input bit en, input int hv, hf, hs, hb, vv, vf, vs, vb);
    exp_t e;
    longint ht, vt, p;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p = (k == 0) ? ht * vt - 1 : (k - 1) % (ht * vt);
    e.x = int'(p % ht);
    e.y = int'(p / ht);
    e.hs = !(e.x >= hv + hf && e.x < hv + hf + hs);
    e.vs = !(e.y >= vv + vf && e.y < vv + vf + vs);
    e.disp = e.x < hv && e.y < vv;
    e.ls = en && e.x == 0;
    e.fs = en && e.x == 0 && e.y == 0;
    return e;
  endfunction
  longint k = 0;
  bit en_last = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= 0;
      en_last <= 1'b0;
    end else begin
      en_last <= pix_en;
      if (pix_en) k <= k + 1;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    e = model(k, en_last, 640, 16, 96, 48, 480, 10, 2, 33);
    chk("d_x", d_x, e.x); chk("d_y", d_y, e.y); chk("d_hsync", d_hs, e.hs); chk("d_vsync", d_vs, e.vs);
    chk("d_disp", d_disp, e.disp); chk("d_fs", d_fs, e.fs); chk("d_ls", d_ls, e.ls);
    e = model(k, en_last, 8, 2, 3, 3, 6, 1, 2, 2);
    chk("s_x", s_x, e.x); chk("s_y", s_y, e.y); chk("s_hsync", s_hs, e.hs); chk("s_vsync", s_vs, e.vs);
    chk("s_disp", s_disp, e.disp); chk("s_fs", s_fs, e.fs); chk("s_ls", s_ls, e.ls);
  end
  initial begin
    int last, nfs, vlow, found;
    pix_en = 1'b1;
    repeat (3) tick();
    chk("rst_x", d_x, 799); chk("rst_y", d_y, 524); chk("rst_hs", d_hs, 1); chk("rst_vs", d_vs, 1);
    chk("rst_disp", d_disp, 0); chk("rst_fs", d_fs, 0); chk("rst_ls", d_ls, 0);
    chk("rst_sx", s_x, 15); chk("rst_sy", s_y, 10);
    reset = 1'b1;
    tick();
    chk("first_x", d_x, 0); chk("first_y", d_y, 0); chk("first_fs", d_fs, 1); chk("first_ls", d_ls, 1);
    chk("first_disp", d_disp, 1); chk("first_hs", d_hs, 1); chk("first_vs", d_vs, 1);
    tick();
    chk("second_x", d_x, 1); chk("second_fs", d_fs, 0); chk("second_ls", d_ls, 0);
    repeat (638) tick();
    chk("x639", d_x, 639); chk("disp639", d_disp, 1);
    tick();
    chk("x640", d_x, 640); chk("disp640", d_disp, 0);
    repeat (15) tick();
    chk("hs655", d_hs, 1);
    tick();
    chk("x656", d_x, 656); chk("hs656", d_hs, 0);
    repeat (95) tick();
    chk("hs751", d_hs, 0);
    tick();
    chk("hs752", d_hs, 1);
    repeat (47) tick();
    chk("x799", d_x, 799); chk("y799", d_y, 0);
    tick();
    chk("wrap_x", d_x, 0); chk("wrap_y", d_y, 1); chk("wrap_ls", d_ls, 1); chk("wrap_fs", d_fs, 0);
    for (int i = 0; i < 400; i++) begin
      pix_en = (i % 2 == 0);
      tick();
      if (!pix_en) begin
        chk("idle_ls", d_ls, 0); chk("idle_fs", d_fs, 0); chk("idle_sls", s_ls, 0);
      end
    end
    pix_en = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    last = -1; nfs = 0; vlow = 0;
    for (int i = 0; i < 3 * 176; i++) begin
      tick();
      if (s_fs) begin
        nfs++;
        if (last >= 0) chk("fs_period", i - last, 176);
        if (nfs == 2) chk("vs_low", vlow, 32);
        last = i;
      end
      if (nfs == 1 && !s_vs) vlow++;
      if (s_y >= 6) chk("disp_low_rows", s_disp, 0);
    end
    chk("fs_count", nfs, 3);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (s_x == 11 && s_y == 8) found = 1;
      else tick();
    end
    chk("reach_11_8", found, 1);
    chk("pre_rst_hs", s_hs, 0); chk("pre_rst_vs", s_vs, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_hs", s_hs, 1); chk("mid_rst_vs", s_vs, 1); chk("mid_rst_x", s_x, 15); chk("mid_rst_y", s_y, 10);
    chk("mid_rst_fs", s_fs, 0); chk("mid_rst_ls", s_ls, 0); chk("mid_rst_dx", d_x, 799); chk("mid_rst_dy", d_y, 524);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rel_x", s_x, 0); chk("rel_y", s_y, 0); chk("rel_fs", s_fs, 1); chk("rel_dfs", d_fs, 1);
    repeat (20) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
